// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand-B source select and the EX-stage forwarding mux.
// Also holds the index map for the per-source selection counters.
package alu_pkg;

    typedef enum logic {
        ALUSRC_REG = 1'b0,
        ALUSRC_IMM = 1'b1
    } alusrc_e;

    // 2'b11 is unused by the hazard unit and falls back to register data.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_e;

    localparam int NUM_SEL_CNT = 2;
    localparam int CNT_IMM     = 0;
    localparam int CNT_REG     = 1;

endpackage

// File: rtl/alu_input_mux_if.sv
// Operand-B select bus: datapath inputs, control, and the registered/statistics outputs.
// Forwarding signals exist only when ALU_INPUT_MUX_FWD_EN is defined.
interface alu_input_mux_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] reg_data;
    logic [DATA_W-1:0] ImmExx;
    logic              alu_src;
    logic              inst_valid;
    logic              cnt_clr;
    logic [DATA_W-1:0] SrcB;
    logic [DATA_W-1:0] SrcB_q;
    logic              SrcB_q_valid;
    logic [CNT_W-1:0]  imm_sel_cnt;
    logic [CNT_W-1:0]  reg_sel_cnt;
`ifdef ALU_INPUT_MUX_FWD_EN
    logic [1:0]        ForwardB;
    logic [DATA_W-1:0] ALUResultM;
    logic [DATA_W-1:0] ResultW;
    logic [DATA_W-1:0] WriteDataE;
`endif

`ifdef ALU_INPUT_MUX_FWD_EN
    modport master (
        output reg_data, ImmExx, alu_src, inst_valid, cnt_clr,
        output ForwardB, ALUResultM, ResultW,
        input  SrcB, SrcB_q, SrcB_q_valid, imm_sel_cnt, reg_sel_cnt,
        input  WriteDataE
    );
    modport slave (
        input  reg_data, ImmExx, alu_src, inst_valid, cnt_clr,
        input  ForwardB, ALUResultM, ResultW,
        output SrcB, SrcB_q, SrcB_q_valid, imm_sel_cnt, reg_sel_cnt,
        output WriteDataE
    );
`else
    modport master (
        output reg_data, ImmExx, alu_src, inst_valid, cnt_clr,
        input  SrcB, SrcB_q, SrcB_q_valid, imm_sel_cnt, reg_sel_cnt
    );
    modport slave (
        input  reg_data, ImmExx, alu_src, inst_valid, cnt_clr,
        output SrcB, SrcB_q, SrcB_q_valid, imm_sel_cnt, reg_sel_cnt
    );
`endif

endinterface

// File: rtl/alu_input_mux_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/alu_input_mux.sv
// ALU operand-B select (rs2 vs. immediate) with a registered probe copy and selection counters.
// Define ALU_INPUT_MUX_FWD_EN to insert the EX-stage forwarding mux ahead of the register leg.
module alu_input_mux
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_input_mux_if.slave bus
);

    logic [DATA_W-1:0] reg_side;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] src_b_q_reg;
    logic              src_b_q_valid_reg;

`ifdef ALU_INPUT_MUX_FWD_EN
    always_comb begin
        reg_side = bus.reg_data;
        case (bus.ForwardB)
            FWD_WB:  reg_side = bus.ResultW;
            FWD_MEM: reg_side = bus.ALUResultM;
            default: reg_side = bus.reg_data;
        endcase
    end

    assign bus.WriteDataE = reg_side;
`else
    assign reg_side = bus.reg_data;
`endif

    // Ternary keeps an X on alu_src visible in simulation rather than silently picking a leg.
    assign src_b   = (bus.alu_src == ALUSRC_IMM) ? bus.ImmExx : reg_side;
    assign bus.SrcB = src_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_b_q_reg       <= '0;
            src_b_q_valid_reg <= 1'b0;
        end else begin
            src_b_q_valid_reg <= bus.inst_valid;
            if (bus.inst_valid) begin
                src_b_q_reg <= src_b;
            end
        end
    end

    assign bus.SrcB_q       = src_b_q_reg;
    assign bus.SrcB_q_valid = src_b_q_valid_reg;

    logic [NUM_SEL_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]       cnt_val [NUM_SEL_CNT];

    assign cnt_inc[CNT_IMM] = bus.inst_valid & (bus.alu_src == ALUSRC_IMM);
    assign cnt_inc[CNT_REG] = bus.inst_valid & (bus.alu_src == ALUSRC_REG);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEL_CNT; gi++) begin : g_sel_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cnt_inc[gi]),
                .clr   (bus.cnt_clr),
                .cnt   (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.imm_sel_cnt = cnt_val[CNT_IMM];
    assign bus.reg_sel_cnt = cnt_val[CNT_REG];

endmodule

// File: tb/tb_alu_input_mux.sv
// Directed bench for alu_input_mux: stimulus pushes expectations to a queue, a monitor
// pops and compares them each time the stimulus marks the outputs as ready to sample.
module tb_alu_input_mux;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    localparam int SEL_SRCB   = 0;
    localparam int SEL_Q      = 1;
    localparam int SEL_QV     = 2;
    localparam int SEL_IMMCNT = 3;
    localparam int SEL_REGCNT = 4;
    localparam int SEL_WDE    = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_input_mux_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    alu_input_mux #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    event sample_ev;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] actual(input int sel);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        case (sel)
            SEL_SRCB:   v = bus.SrcB;
            SEL_Q:      v = bus.SrcB_q;
            SEL_QV:     v = {31'd0, bus.SrcB_q_valid};
            SEL_IMMCNT: v = {{(32-CNT_W){1'b0}}, bus.imm_sel_cnt};
            SEL_REGCNT: v = {{(32-CNT_W){1'b0}}, bus.reg_sel_cnt};
`ifdef ALU_INPUT_MUX_FWD_EN
            SEL_WDE:    v = bus.WriteDataE;
`endif
            default:    v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    // Monitor: drains every queued expectation when outputs are declared stable.
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                a = actual(e.sel);
                total++;
                if (a !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", e.name, a, e.exp, $time);
                end else begin
                    $display("ok   %s: 0x%0h (t=%0t)", e.name, a, $time);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic sample();
        -> sample_ev;
        #1;
    endtask

    // Advance one active edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] rd, input logic [31:0] imm,
                         input logic src, input logic vld, input logic clr);
        bus.reg_data   = rd;
        bus.ImmExx     = imm;
        bus.alu_src    = src;
        bus.inst_valid = vld;
        bus.cnt_clr    = clr;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_INPUT_MUX_FWD_EN
        bus.ForwardB   = 2'b00;
        bus.ALUResultM = '0;
        bus.ResultW    = '0;
`endif
        #1;
        @(negedge clk);
        // Reset state, including an edge with inst_valid=1 held off by reset.
        bus.inst_valid = 1'b1;
        bus.alu_src    = 1'b1;
        tick();
        expect_val("rst_q", SEL_Q, 32'h0);
        expect_val("rst_qv", SEL_QV, 32'h0);
        expect_val("rst_immcnt", SEL_IMMCNT, 32'h0);
        expect_val("rst_regcnt", SEL_REGCNT, 32'h0);
        sample();
        bus.inst_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Pure combinational select, checked 10 ns after each change.
        drive(32'h5, 32'h4, 1'b0, 1'b0, 1'b0);
        #10; expect_val("sel_reg_5", SEL_SRCB, 32'h5); sample();
        bus.alu_src = 1'b1;
        #9;  expect_val("sel_imm_4", SEL_SRCB, 32'h4); sample();
        drive(32'h10, 32'h8, 1'b0, 1'b0, 1'b0);
        #9;  expect_val("sel_reg_10", SEL_SRCB, 32'h10); sample();
        bus.alu_src = 1'b1;
        #9;  expect_val("sel_imm_8", SEL_SRCB, 32'h8); sample();
        drive(32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 1'b0, 1'b0);
        #9;  expect_val("sel_imm_full", SEL_SRCB, 32'h8000_0001); sample();
        expect_val("idle_immcnt", SEL_IMMCNT, 32'h0);
        expect_val("idle_qv", SEL_QV, 32'h0);
        sample();

        // Build up nonzero state, then assert reset between edges.
        @(negedge clk);
        drive(32'h77, 32'h66, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        expect_val("pre_rst_immcnt", SEL_IMMCNT, 32'h2);
        expect_val("pre_rst_q", SEL_Q, 32'h66);
        sample();
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("async_q", SEL_Q, 32'h0);
        expect_val("async_qv", SEL_QV, 32'h0);
        expect_val("async_immcnt", SEL_IMMCNT, 32'h0);
        expect_val("async_regcnt", SEL_REGCNT, 32'h0);
        sample();
        bus.alu_src = 1'b0;
        #1; expect_val("rst_srcb_follow", SEL_SRCB, 32'h77); sample();
        @(negedge clk);
        expect_val("rst_hold_q", SEL_Q, 32'h0);
        expect_val("rst_hold_qv", SEL_QV, 32'h0);
        sample();
        bus.inst_valid = 1'b0;
        rst_n = 1'b1;

        // Three immediate selections then two register selections.
        drive(32'h200, 32'h100, 1'b1, 1'b1, 1'b0);
        tick();
        expect_val("first_cap_q", SEL_Q, 32'h100);
        expect_val("first_cap_qv", SEL_QV, 32'h1);
        expect_val("first_cap_imm", SEL_IMMCNT, 32'h1);
        sample();
        bus.ImmExx = 32'h101; tick();
        bus.ImmExx = 32'h102; tick();
        drive(32'h200, 32'h103, 1'b0, 1'b1, 1'b0); tick();
        bus.reg_data = 32'h201; tick();
        expect_val("last_cap_q", SEL_Q, 32'h201);
        expect_val("last_cap_qv", SEL_QV, 32'h1);
        sample();
        drive(32'h300, 32'h301, 1'b1, 1'b0, 1'b0);
        tick();
        expect_val("hold_q", SEL_Q, 32'h201);
        expect_val("hold_qv", SEL_QV, 32'h0);
        expect_val("mix_immcnt", SEL_IMMCNT, 32'h3);
        expect_val("mix_regcnt", SEL_REGCNT, 32'h2);
        sample();

        // Twenty immediate selections saturate the 4-bit counter at 15.
        drive(32'h0, 32'h55, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 10) begin
                expect_val("sat_mid_immcnt", SEL_IMMCNT, 32'hE);
                sample();
            end
        end
        expect_val("sat_immcnt", SEL_IMMCNT, 32'hF);
        expect_val("sat_regcnt", SEL_REGCNT, 32'h2);
        sample();

        // Clear wins over a simultaneous valid selection; capture still happens.
        drive(32'h0, 32'h99, 1'b1, 1'b1, 1'b1);
        tick();
        expect_val("clr_immcnt", SEL_IMMCNT, 32'h0);
        expect_val("clr_regcnt", SEL_REGCNT, 32'h0);
        expect_val("clr_q", SEL_Q, 32'h99);
        sample();
        drive(32'h42, 32'h99, 1'b0, 1'b1, 1'b0);
        tick();
        expect_val("post_clr_regcnt", SEL_REGCNT, 32'h1);
        expect_val("post_clr_immcnt", SEL_IMMCNT, 32'h0);
        sample();
        bus.inst_valid = 1'b0;

`ifdef ALU_INPUT_MUX_FWD_EN
        drive(32'h1, 32'h7, 1'b0, 1'b0, 1'b0);
        bus.ResultW    = 32'h2;
        bus.ALUResultM = 32'h3;
        bus.ForwardB   = 2'b01;
        #10; expect_val("fwd_wb", SEL_SRCB, 32'h2); sample();
        bus.ForwardB = 2'b10;
        #9;  expect_val("fwd_mem", SEL_SRCB, 32'h3);
        expect_val("fwd_mem_wde", SEL_WDE, 32'h3); sample();
        bus.ForwardB = 2'b11;
        #9;  expect_val("fwd_rsvd", SEL_SRCB, 32'h1); sample();
        bus.ForwardB = 2'b00;
        #9;  expect_val("fwd_none", SEL_SRCB, 32'h1); sample();
        bus.ForwardB = 2'b01;
        bus.alu_src  = 1'b1;
        #9;  expect_val("fwd_imm_wins", SEL_SRCB, 32'h7);
        expect_val("fwd_imm_wde", SEL_WDE, 32'h2); sample();
`endif

        #5;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
